conv_window_buffer: RTL and testbench

Streaming window generator that sits directly upstream of `convolver_complex`. Accepts one image pixel per valid cycle in raster order, holds the last KERNEL_SIZE-1 image rows in line buffers, and presents every fully populated KERNEL_SIZE×KERNEL_SIZE window on a flattened bus. The bus layout is exactly what `convolver_complex.pixel_in` consumes. Produces (IMAGE_SIZE-KERNEL_SIZE+1)² windows per frame (valid-only convolution, no padding).

---
 rtl/conv_pkg.sv | 18 +
 rtl/conv_window_buffer_if.sv | 23 ++
 rtl/conv_line_buffer.sv | 33 +++
 rtl/conv_window_buffer.sv | 115 +++++++++++
 tb/tb_conv_window_buffer.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared sizing for the window buffer and the downstream convolver, so both
// ends of the flattened window bus always agree on width.
package conv_pkg;

  localparam int DATA_WIDTH   = 16;
  localparam int KERNEL_SIZE  = 5;
  localparam int IMAGE_SIZE   = 28;
  localparam int WINDOW_WIDTH = KERNEL_SIZE * KERNEL_SIZE * DATA_WIDTH;
  localparam int COORD_WIDTH  = $clog2(IMAGE_SIZE);

  typedef logic [DATA_WIDTH-1:0]  pixel_t;
  typedef logic [COORD_WIDTH-1:0] coord_t;

  function automatic logic is_last_coord(input coord_t c);
    return c == coord_t'(IMAGE_SIZE - 1);
  endfunction

endpackage

// File: rtl/conv_window_buffer_if.sv
// Pixel stream in, window stream out; the source drives pixels and the
// buffer drives windows.
interface conv_window_buffer_if;
  import conv_pkg::*;

  logic                    pixel_valid;
  pixel_t                  pixel_in;
  logic                    start_of_frame;
  logic [WINDOW_WIDTH-1:0] window_out;
  logic                    window_valid;
  logic                    frame_done;

  modport master (
    output pixel_valid, pixel_in, start_of_frame,
    input  window_out, window_valid, frame_done
  );

  modport slave (
    input  pixel_valid, pixel_in, start_of_frame,
    output window_out, window_valid, frame_done
  );

endinterface

// File: rtl/conv_line_buffer.sv
// One image row of delay: circular buffer whose output is the entry about to
// be overwritten, so it presents the pixel one row above the incoming one.
module conv_line_buffer
  import conv_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   enable,
  input  pixel_t wr_data,
  output pixel_t rd_data
);

  pixel_t mem [IMAGE_SIZE];
  coord_t ptr;

  assign rd_data = mem[ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (enable) begin
      ptr <= is_last_coord(ptr) ? '0 : ptr + coord_t'(1);
    end
  end

  // Contents need no reset: frame validity gating never exposes stale rows.
  always_ff @(posedge clk) begin
    if (enable) begin
      mem[ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/conv_window_buffer.sv
// Raster-order pixel stream to KERNEL_SIZE x KERNEL_SIZE sliding windows,
// emitting only fully populated windows (no padding).
module conv_window_buffer
  import conv_pkg::*;
(
  input  logic clk,
  input  logic reset,
  conv_window_buffer_if.slave bus
);

  coord_t col, row, cur_col, cur_row;
  logic   accept, complete, last;

  pixel_t lb_in   [KERNEL_SIZE-1];
  pixel_t taps    [KERNEL_SIZE-1];
  pixel_t column  [KERNEL_SIZE];
  pixel_t win      [KERNEL_SIZE][KERNEL_SIZE];
  pixel_t win_next [KERNEL_SIZE][KERNEL_SIZE];

  logic [WINDOW_WIDTH-1:0] win_flat;
  logic [WINDOW_WIDTH-1:0] window_reg;
  logic                    valid_reg;
  logic                    done_reg;

  assign accept   = bus.pixel_valid;
  assign cur_col  = bus.start_of_frame ? '0 : col;
  assign cur_row  = bus.start_of_frame ? '0 : row;
  assign complete = (cur_row >= coord_t'(KERNEL_SIZE - 1)) &&
                    (cur_col >= coord_t'(KERNEL_SIZE - 1));
  assign last     = is_last_coord(cur_row) && is_last_coord(cur_col);

  genvar b;
  generate
    for (b = 0; b < KERNEL_SIZE - 1; b++) begin : g_line
      conv_line_buffer u_line (
        .clk     (clk),
        .reset   (reset),
        .enable  (accept),
        .wr_data (lb_in[b]),
        .rd_data (taps[b])
      );
    end
  endgenerate

  // Row 0 of the column is the oldest line, the last row is the new pixel.
  always_comb begin
    lb_in[0] = bus.pixel_in;
    for (int i = 1; i < KERNEL_SIZE - 1; i++) lb_in[i] = taps[i-1];
    column[KERNEL_SIZE-1] = bus.pixel_in;
    for (int i = 0; i < KERNEL_SIZE - 1; i++) column[KERNEL_SIZE-2-i] = taps[i];
  end

  always_comb begin
    win_next = win;
    for (int i = 0; i < KERNEL_SIZE; i++) begin
      for (int j = 0; j < KERNEL_SIZE - 1; j++) win_next[i][j] = win[i][j+1];
      win_next[i][KERNEL_SIZE-1] = column[i];
    end
  end

  always_comb begin
    win_flat = '0;
    for (int i = 0; i < KERNEL_SIZE; i++)
      for (int j = 0; j < KERNEL_SIZE; j++)
        win_flat[(i*KERNEL_SIZE+j)*DATA_WIDTH +: DATA_WIDTH] = win_next[i][j];
  end

  // Coordinate of the next accepted pixel; start_of_frame rebases to (0,0).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (last) begin
        col <= '0;
        row <= '0;
      end else if (is_last_coord(cur_col)) begin
        col <= '0;
        row <= cur_row + coord_t'(1);
      end else begin
        col <= cur_col + coord_t'(1);
        row <= cur_row;
      end
    end else if (bus.start_of_frame) begin
      col <= '0;
      row <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win <= '{default: '0};
    end else if (accept) begin
      win <= win_next;
    end
  end

  // The output copy only moves on complete windows, so partial shifts stay hidden.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      window_reg <= '0;
      valid_reg  <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      valid_reg <= accept && complete;
      done_reg  <= accept && complete && last;
      if (accept && complete) window_reg <= win_flat;
    end
  end

  assign bus.window_out   = window_reg;
  assign bus.window_valid = valid_reg;
  assign bus.frame_done   = done_reg;

endmodule

// File: tb/tb_conv_window_buffer.sv
// Self-checking bench for conv_window_buffer: coordinate-based image model,
// ramp checkpoint table, and multi-frame / reset / restart sequences.
module tb_conv_window_buffer;
  import conv_pkg::*;

  localparam int K  = KERNEL_SIZE;
  localparam int N  = IMAGE_SIZE;
  localparam int DW = DATA_WIDTH;
  localparam int W  = WINDOW_WIDTH;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  conv_window_buffer_if bus();

  conv_window_buffer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: the current frame stored by coordinate.
  pixel_t       img [N][N];
  int           m_col, m_row;
  logic [W-1:0] exp_win;
  logic         exp_valid, exp_fd;

  int   win_count, fd_count, accepted, first_win_at;
  int   first_e0, first_e24;
  logic after_a, b_seen;
  int   b_e0, b_e24;

  typedef struct {
    int   n;
    logic v;
    logic fd;
    int   e0;
    int   e12;
    int   e24;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step(input logic valid, input pixel_t data, input logic sof);
    int r, c;
    exp_valid = 1'b0;
    exp_fd    = 1'b0;
    if (valid) begin
      r = sof ? 0 : m_row;
      c = sof ? 0 : m_col;
      img[r][c] = data;
      if (r >= K-1 && c >= K-1) begin
        exp_valid = 1'b1;
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++)
            exp_win[(i*K+j)*DW +: DW] = img[r-K+1+i][c-K+1+j];
        exp_fd = (r == N-1) && (c == N-1);
      end
      c++;
      if (c == N) begin
        c = 0;
        r++;
        if (r == N) r = 0;
      end
      m_col = c;
      m_row = r;
    end else if (sof) begin
      m_col = 0;
      m_row = 0;
    end
  endtask

  task automatic check_output();
    logic found;
    check("window_valid", W'(bus.window_valid), W'(exp_valid));
    check("frame_done", W'(bus.frame_done), W'(exp_fd));
    check("window_out", bus.window_out, exp_win);
    if (bus.window_valid) begin
      win_count++;
      if (first_win_at < 0) begin
        first_win_at = accepted;
        first_e0  = int'(bus.window_out[0 +: DW]);
        first_e24 = int'(bus.window_out[24*DW +: DW]);
      end
      if (after_a) begin
        found = 1'b0;
        for (int e = 0; e < K*K; e++)
          if (bus.window_out[e*DW +: DW] == 16'h7FFF) found = 1'b1;
        check("no_frame_a_data", W'(found), W'(0));
        if (!b_seen) begin
          b_seen = 1'b1;
          b_e0   = int'(bus.window_out[0 +: DW]);
          b_e24  = int'(bus.window_out[24*DW +: DW]);
        end
      end
    end
    if (bus.frame_done) fd_count++;
  endtask

  task automatic apply_stimulus(input logic valid, input pixel_t data, input logic sof);
    @(negedge clk);
    bus.pixel_valid    = valid;
    bus.pixel_in       = data;
    bus.start_of_frame = sof;
    @(posedge clk);
    model_step(valid, data, sof);
    if (valid) accepted++;
    #1;
    check_output();
  endtask

  task automatic clear_stats();
    win_count    = 0;
    fd_count     = 0;
    accepted     = 0;
    first_win_at = -1;
    first_e0     = -1;
    first_e24    = -1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    bus.pixel_valid    = 1'b0;
    bus.start_of_frame = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("reset_window_valid", W'(bus.window_valid), W'(0));
    check("reset_frame_done", W'(bus.frame_done), W'(0));
    check("reset_window_out", bus.window_out, W'(0));
    m_col     = 0;
    m_row     = 0;
    exp_win   = '0;
    exp_valid = 1'b0;
    exp_fd    = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic ramp_frame(input logic toggle);
    for (int p = 0; p < N*N; p++) begin
      apply_stimulus(1'b1, pixel_t'(p), 1'b0);
      if (toggle) apply_stimulus(1'b0, pixel_t'($urandom), 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    tests_failed++;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    int p;
    tbl[0] = '{n: 116, v: 1'b0, fd: 1'b0, e0: 0,   e12: 0,   e24: 0};
    tbl[1] = '{n: 117, v: 1'b1, fd: 1'b0, e0: 0,   e12: 58,  e24: 116};
    tbl[2] = '{n: 118, v: 1'b1, fd: 1'b0, e0: 1,   e12: 59,  e24: 117};
    tbl[3] = '{n: 140, v: 1'b1, fd: 1'b0, e0: 23,  e12: 81,  e24: 139};
    tbl[4] = '{n: 141, v: 1'b0, fd: 1'b0, e0: 0,   e12: 0,   e24: 0};
    tbl[5] = '{n: 145, v: 1'b1, fd: 1'b0, e0: 28,  e12: 86,  e24: 144};
    tbl[6] = '{n: 784, v: 1'b1, fd: 1'b1, e0: 667, e12: 725, e24: 783};

    bus.pixel_valid    = 1'b0;
    bus.pixel_in       = '0;
    bus.start_of_frame = 1'b0;
    after_a = 1'b0;
    b_seen  = 1'b0;
    reset   = 1'b1;
    #3 reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("por_window_valid", W'(bus.window_valid), W'(0));
    check("por_frame_done", W'(bus.frame_done), W'(0));
    check("por_window_out", bus.window_out, W'(0));
    m_col = 0; m_row = 0; exp_win = '0; exp_valid = 1'b0; exp_fd = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Continuous ramp frame with checkpoint table
    clear_stats();
    p = 0;
    for (int k = 0; k < 7; k++) begin
      while (accepted < tbl[k].n) begin
        apply_stimulus(1'b1, pixel_t'(p), 1'b0);
        p++;
      end
      check("tbl_valid", W'(bus.window_valid), W'(tbl[k].v));
      check("tbl_frame_done", W'(bus.frame_done), W'(tbl[k].fd));
      if (tbl[k].v) begin
        check("tbl_elem0", W'(bus.window_out[0 +: DW]), W'(tbl[k].e0));
        check("tbl_elem12", W'(bus.window_out[12*DW +: DW]), W'(tbl[k].e12));
        check("tbl_elem24", W'(bus.window_out[24*DW +: DW]), W'(tbl[k].e24));
      end
    end
    check("ramp_windows", W'(win_count), W'(576));
    check("ramp_frame_done", W'(fd_count), W'(1));
    check("ramp_first_at", W'(first_win_at), W'(117));

    // Same frame with pixel_valid toggling
    clear_stats();
    ramp_frame(1'b1);
    check("toggle_windows", W'(win_count), W'(576));
    check("toggle_frame_done", W'(fd_count), W'(1));
    check("toggle_first_at", W'(first_win_at), W'(117));

    // Reset mid-frame, then a full frame
    clear_stats();
    for (int q = 0; q < 300; q++) apply_stimulus(1'b1, pixel_t'(q), 1'b0);
    apply_reset();
    clear_stats();
    ramp_frame(1'b0);
    check("rst_windows", W'(win_count), W'(576));
    check("rst_first_at", W'(first_win_at), W'(117));
    check("rst_first_elem0", W'(first_e0), W'(0));

    // Back-to-back frames: saturated frame then ramp
    clear_stats();
    for (int q = 0; q < N*N; q++) begin
      apply_stimulus(1'b1, 16'h7FFF, 1'b0);
      if (bus.frame_done) after_a = 1'b1;
    end
    check("b2b_a_done", W'(after_a), W'(1));
    after_a = 1'b1;
    ramp_frame(1'b0);
    after_a = 1'b0;
    check("b2b_windows", W'(win_count), W'(1152));
    check("b2b_frame_done", W'(fd_count), W'(2));
    check("b2b_b_elem0", W'(b_e0), W'(0));
    check("b2b_b_elem24", W'(b_e24), W'(116));

    // start_of_frame restart on the 50th pixel
    clear_stats();
    for (int q = 0; q < 49; q++) apply_stimulus(1'b1, pixel_t'(q), 1'b0);
    clear_stats();
    apply_stimulus(1'b1, pixel_t'(0), 1'b1);
    for (int q = 1; q < N*N; q++) apply_stimulus(1'b1, pixel_t'(q), 1'b0);
    check("sof_first_at", W'(first_win_at), W'(117));
    check("sof_first_elem24", W'(first_e24), W'(116));
    check("sof_frame_done", W'(fd_count), W'(1));
    check("sof_windows", W'(win_count), W'(576));

    // Randomized traffic, including idle start_of_frame pulses
    clear_stats();
    for (int q = 0; q < 4000; q++)
      apply_stimulus($urandom_range(0, 3) != 0, pixel_t'($urandom),
                     $urandom_range(0, 799) == 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
